// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and state type for the instruction fetch responder
package ifetch_pkg;

  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/inst_ram.sv
// rtl/inst_ram.sv - DEPTHx32 word array, one write port, one registered read port
module inst_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Both ports update with non-blocking writes, so a same-index read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - instruction fetch responder: address check, latency FSM, response handshake
module inst_mem_resp import ifetch_pkg::*; #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [63:0]   instaddr,
  output logic          req_ready,
  output logic [31:0]   inst,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          fetch_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 2;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q;
  logic [63:0]   offset;
  logic          addr_err;
  logic          accept;
  logic [31:0]   rd_data;

  assign offset   = instaddr - BASE_ADDR;
  assign addr_err = (instaddr < BASE_ADDR) || (offset >= SPAN) || (instaddr[1:0] != 2'b00);
  assign accept   = ce && req_ready;

  // Error fetches never touch the array; the NOP is substituted at the output.
  inst_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (accept && !addr_err),
    .rd_addr (offset[AW+1:2]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) err_q <= addr_err;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_ready  = 1'b0;
    inst_valid = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      RESP: begin
        inst_valid = 1'b1;
        req_ready  = inst_ready;
      end
      default: ;
    endcase

    case (state)
      WAIT: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - CW'(1);
      end
      RESP: begin
        if (inst_ready) state_n = IDLE;
      end
      default: ;
    endcase

    // A new accept (from IDLE or on the RESP handshake edge) overrides the above.
    if (accept) begin
      if (LATENCY == 1) begin
        state_n = RESP;
        cnt_n   = '0;
      end else begin
        state_n = WAIT;
        cnt_n   = CW'(LATENCY - 1);
      end
    end
  end

  assign fetch_err = (state == RESP) && err_q;
  assign inst      = (state != RESP) ? 32'h0 : (err_q ? NOP_INST : rd_data);

endmodule
